univ_reg: RTL and testbench
===========================

Name: univ_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop with complementary output.
- A WIDTH-bit register that can, per clock: hold, parallel load, shift, rotate, increment or decrement.
- Drives a true output, a complemented output, a registered carry/shift-out flag and a zero flag.
- Used as the general-purpose storage, shift and count element in datapaths that previously chained discrete flip-flops.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded into q on reset and on synchronous clear; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active-low.
- en  input  1  operation enable; when 0 the register holds.
- sclr  input  1  synchronous clear to RESET_VAL; has priority over en and mode.
- mode  input  3  operation select (encodings under Behaviour).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for the shift modes.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  bitwise complement of q, combinational.
- co  output  1  registered carry, borrow or shifted-out bit.
- zero  output  1  high when q equals 0, combinational.

Behaviour:
- Reset: rstn low forces q=RESET_VAL and co=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-operation aborts that operation.
  - The first clock edge after rstn rises executes normally.
- Edge priority, evaluated on every rising clk edge with rstn high:
  - sclr=1: q<=RESET_VAL, co<=0.
  - Otherwise en=0: q and co hold.
  - Otherwise execute mode.
- Mode encodings (all updates take effect at the edge; latency 1 cycle):
  - 000 HOLD: q and co unchanged.
  - 001 LOAD: q<=d, co<=0.
  - 010 SHL: q<={q[WIDTH-2:0],sin}, co<=q[WIDTH-1].
  - 011 SHR: q<={sin,q[WIDTH-1:1]}, co<=q[0].
  - 100 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}, co<=q[WIDTH-1].
  - 101 ROR: q<={q[0],q[WIDTH-1:1]}, co<=q[0].
  - 110 INC: {co,q}<=q+1 computed in WIDTH+1 bits.
    - Wrap: all-ones to 0 sets co=1; otherwise co=0.
  - 111 DEC: q<=q-1 modulo 2^WIDTH.
    - co=1 only on borrow (q was 0, wraps to all-ones); otherwise co=0.
- Combinational outputs: qbar=~q and zero=(q==0) follow q with no additional cycle.
  - After reset, qbar=~RESET_VAL and zero=(RESET_VAL==0).
- sin is ignored in every mode except SHL and SHR.
- d is ignored in every mode except LOAD.
- Simultaneous sclr and en with any mode: the clear wins.
- Unsigned arithmetic only; no saturation.

Decomposition:
- Shared package univ_reg_pkg holds the 3-bit mode localparams MODE_HOLD through MODE_DEC.
  - Bench and RTL both use these names.
- One natural sub-module, univ_reg_next: purely combinational.
  - Inputs: q, d, sin, mode.
  - Outputs: the next q and the next co.
- The top level univ_reg contains only the state flops, the priority logic (reset, sclr, en) and the qbar/zero assigns.

Test Plan (all scenarios use WIDTH=8, RESET_VAL=0):
- Reset mid-operation: load 8'hA5, then pull rstn low between edges.
  - q=00, co=0, qbar=FF, zero=1 immediately, before the next edge.
  - After rstn rises, the next edge executes normally.
- LOAD then SHL: load 8'h81, then SHL with sin=1.
  - q=03, co=1.
  - A further SHL with sin=0 gives q=06, co=0.
- ROR wrap: load 8'h01, then ROR.
  - q=80, co=1.
  - Eight consecutive RORs return q to 80 and leave zero=0 throughout.
- INC/DEC boundaries:
  - Load FF, then INC: q=00, co=1, zero=1.
  - Then DEC: q=FF, co=1.
  - Then DEC: q=FE, co=0.
- Enable and clear priority:
  - en=0 with mode=INC for 3 cycles: q unchanged.
  - sclr=1 with en=1, mode=LOAD, d=3C: q=00, co=0.
- Random soak: 100 cycles of random en, sclr, mode, d and sin, with a random rstn pulse.
  - Checked each cycle against a reference model of the mode table.
  - qbar==~q and zero==(q==0) checked every cycle.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared mode encodings for the universal register and the code that drives it.
// The register can hold, load, shift, rotate, increment or decrement.
package univ_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  // Only HOLD leaves the carry flag untouched; every other mode rewrites it.
  function automatic logic mode_updates_co(input logic [2:0] mode_i);
    return (mode_i != MODE_HOLD);
  endfunction

endpackage

// File: rtl/univ_reg_next.sv
// Purely combinational next-state datapath: given the current contents and the
// mode, produce the next register value and the next carry/shift-out bit.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] q_nxt_o,
  output logic             co_nxt_o
);

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;

  // The extra top bit is the carry for INC and the borrow for DEC.
  assign inc_s = {1'b0, q_i} + ONE_EXT;
  assign dec_s = {1'b0, q_i} - ONE_EXT;

  // Mode table: next value and next carry/shift-out.
  always_comb begin
    q_nxt_o  = q_i;
    co_nxt_o = 1'b0;
    case (mode_i)
      MODE_HOLD: begin
        q_nxt_o  = q_i;
        co_nxt_o = 1'b0;
      end
      MODE_LOAD: begin
        q_nxt_o  = d_i;
        co_nxt_o = 1'b0;
      end
      MODE_SHL: begin
        q_nxt_o  = {q_i[WIDTH-2:0], sin_i};
        co_nxt_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt_o  = {sin_i, q_i[WIDTH-1:1]};
        co_nxt_o = q_i[0];
      end
      MODE_ROL: begin
        q_nxt_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        co_nxt_o = q_i[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt_o  = {q_i[0], q_i[WIDTH-1:1]};
        co_nxt_o = q_i[0];
      end
      MODE_INC: begin
        q_nxt_o  = inc_s[WIDTH-1:0];
        co_nxt_o = inc_s[WIDTH];
      end
      MODE_DEC: begin
        q_nxt_o  = dec_s[WIDTH-1:0];
        co_nxt_o = dec_s[WIDTH];
      end
      default: begin
        q_nxt_o  = q_i;
        co_nxt_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: state flops, reset/clear/enable priority and
// the combinational complement and zero-detect outputs.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sclr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             co,
  output logic             zero
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             co_q;
  logic             co_d;
  logic [WIDTH-1:0] nxt_q_s;
  logic             nxt_co_s;

  univ_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i      (q_q),
    .d_i      (d),
    .sin_i    (sin),
    .mode_i   (mode),
    .q_nxt_o  (nxt_q_s),
    .co_nxt_o (nxt_co_s)
  );

  // Edge priority: clear beats enable, enable gates the mode result.
  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    if (sclr) begin
      q_d  = RESET_VAL;
      co_d = 1'b0;
    end else if (en && mode_updates_co(mode)) begin
      q_d  = nxt_q_s;
      co_d = nxt_co_s;
    end else begin
      q_d  = q_q;
      co_d = co_q;
    end
  end

  // State flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q  <= RESET_VAL;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign q    = q_q;
  assign co   = co_q;
  assign qbar = ~q_q;
  assign zero = (q_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg (WIDTH=8, RESET_VAL=0): the driver queues the
// expected {co,q} per step, a negedge monitor pops and compares all outputs.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       sclr;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       co;
  logic       zero;

  logic [8:0] exp_fifo[$];
  string      name_fifo[$];
  int         checks;
  int         errors;

  logic [7:0] mq;
  logic       mco;

  logic [8:0] mon_e;
  string      mon_nm;

  univ_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .sclr (sclr),
    .mode (mode),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .qbar (qbar),
    .co   (co),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expectation consumed per negedge, all four outputs compared.
  always @(negedge clk) begin
    if (exp_fifo.size() > 0) begin
      mon_e  = exp_fifo.pop_front();
      mon_nm = name_fifo.pop_front();
      chk(mon_nm, "q",    q,              mon_e[7:0]);
      chk(mon_nm, "co",   {7'd0, co},     {7'd0, mon_e[8]});
      chk(mon_nm, "qbar", qbar,           ~mon_e[7:0]);
      chk(mon_nm, "zero", {7'd0, zero},   {7'd0, (mon_e[7:0] == 8'h00)});
    end
  end

  function automatic logic [8:0] ref_next(input logic [7:0] cq, input logic cco,
                                          input logic e_i, input logic s_i,
                                          input logic [2:0] m_i, input logic [7:0] d_i,
                                          input logic si_i);
    logic [8:0] r;
    if (s_i) return 9'h000;
    if (!e_i) return {cco, cq};
    case (m_i)
      MODE_HOLD: r = {cco, cq};
      MODE_LOAD: r = {1'b0, d_i};
      MODE_SHL:  r = {cq[7], cq[6:0], si_i};
      MODE_SHR:  r = {cq[0], si_i, cq[7:1]};
      MODE_ROL:  r = {cq[7], cq[6:0], cq[7]};
      MODE_ROR:  r = {cq[0], cq[0], cq[7:1]};
      MODE_INC:  r = {1'b0, cq} + 9'd1;
      MODE_DEC:  r = {(cq == 8'h00), cq - 8'd1};
      default:   r = {cco, cq};
    endcase
    return r;
  endfunction

  task automatic drive(input logic e_i, input logic s_i, input logic [2:0] m_i,
                       input logic [7:0] d_i, input logic si_i);
    en   = e_i;
    sclr = s_i;
    mode = m_i;
    d    = d_i;
    sin  = si_i;
  endtask

  task automatic step_dir(input logic e_i, input logic s_i, input logic [2:0] m_i,
                          input logic [7:0] d_i, input logic si_i,
                          input logic [7:0] xq, input logic xco, input string nm);
    drive(e_i, s_i, m_i, d_i, si_i);
    @(posedge clk);
    mq  = xq;
    mco = xco;
    exp_fifo.push_back({xco, xq});
    name_fifo.push_back(nm);
    #1;
  endtask

  task automatic step_rand(input string nm);
    logic       e_i, s_i, si_i;
    logic [2:0] m_i;
    logic [7:0] d_i;
    logic [8:0] r;
    e_i  = 1'($urandom_range(0, 3) != 0);
    s_i  = 1'($urandom_range(0, 9) == 0);
    m_i  = 3'($urandom_range(0, 7));
    d_i  = 8'($urandom_range(0, 255));
    si_i = 1'($urandom_range(0, 1));
    r    = ref_next(mq, mco, e_i, s_i, m_i, d_i, si_i);
    drive(e_i, s_i, m_i, d_i, si_i);
    @(posedge clk);
    mq  = r[7:0];
    mco = r[8];
    exp_fifo.push_back(r);
    name_fifo.push_back(nm);
    #1;
  endtask

  // Pull rstn low between edges and expect reset values before the next edge.
  task automatic rst_pulse(input string nm);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    mq  = 8'h00;
    mco = 1'b0;
    exp_fifo.push_back(9'h000);
    name_fifo.push_back(nm);
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int rp;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0);
    mq  = 8'h00;
    mco = 1'b0;
    #2;
    exp_fifo.push_back(9'h000);
    name_fifo.push_back("reset");
    @(negedge clk);
    #1;
    rstn = 1'b1;

    step_dir(1'b1, 1'b0, MODE_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, "load_a5");
    rst_pulse("rst_mid");
    step_dir(1'b1, 1'b0, MODE_LOAD, 8'h81, 1'b1, 8'h81, 1'b0, "load_81");
    step_dir(1'b1, 1'b0, MODE_SHL,  8'h55, 1'b1, 8'h03, 1'b1, "shl_1");
    step_dir(1'b1, 1'b0, MODE_SHL,  8'hFF, 1'b0, 8'h06, 1'b0, "shl_0");
    step_dir(1'b1, 1'b0, MODE_LOAD, 8'h01, 1'b1, 8'h01, 1'b0, "load_01");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'hFF, 1'b0, 8'h80, 1'b1, "ror_wrap");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h40, 1'b0, "ror8_1");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h20, 1'b0, "ror8_2");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h10, 1'b0, "ror8_3");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h08, 1'b0, "ror8_4");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h04, 1'b0, "ror8_5");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h02, 1'b0, "ror8_6");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h01, 1'b0, "ror8_7");
    step_dir(1'b1, 1'b0, MODE_ROR,  8'h00, 1'b1, 8'h80, 1'b1, "ror8_8");
    step_dir(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0, "load_ff");
    step_dir(1'b1, 1'b0, MODE_INC,  8'h12, 1'b1, 8'h00, 1'b1, "inc_wrap");
    step_dir(1'b1, 1'b0, MODE_DEC,  8'h34, 1'b1, 8'hFF, 1'b1, "dec_borrow");
    step_dir(1'b1, 1'b0, MODE_DEC,  8'h00, 1'b0, 8'hFE, 1'b0, "dec_plain");
    step_dir(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'hFE, 1'b0, "en0_a");
    step_dir(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'hFE, 1'b0, "en0_b");
    step_dir(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'hFE, 1'b0, "en0_c");
    step_dir(1'b1, 1'b0, MODE_ROL,  8'h00, 1'b0, 8'hFD, 1'b1, "rol");
    step_dir(1'b1, 1'b0, MODE_HOLD, 8'h77, 1'b1, 8'hFD, 1'b1, "hold_co");
    step_dir(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'hFD, 1'b1, "en0_co");
    step_dir(1'b1, 1'b0, MODE_SHR,  8'h00, 1'b1, 8'hFE, 1'b1, "shr_1");
    step_dir(1'b1, 1'b0, MODE_SHR,  8'hFF, 1'b0, 8'h7F, 1'b0, "shr_0");
    step_dir(1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 8'h00, 1'b0, "sclr_wins");
    step_dir(1'b1, 1'b0, MODE_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, "dec_zero");

    rp = $urandom_range(10, 90);
    for (int i = 0; i < 100; i++) begin
      if (i == rp) rst_pulse("soak_rst");
      step_rand($sformatf("soak_%0d", i));
    end

    for (int i = 0; i < 10 && exp_fifo.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_fifo.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_fifo.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
